// File: rtl/alsu_step_ctrl.sv
// Step-button front end for the ALSU: debounces btn_step, sequences A/B/opcode entry and captures the result.
// Optional ALSU_LIVE_RESULT_EN: in S_SHOW, opcode follows sw_op and the result is re-captured every cycle.
module alsu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ALU_LATENCY     = 1
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       btn_step,
    input  logic [2:0] sw_data,
    input  logic [2:0] sw_op,
    input  logic [5:0] alu_out,
    input  logic       alu_invalid,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic [2:0] opcode,
    output logic [5:0] out_ALU,
    output logic       valid,
    output logic [2:0] state_led
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       LAT      = 3'(ALU_LATENCY);

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_EXEC,
        S_CAP,
        S_SHOW
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       sync_q;
    logic             db_level;
    logic [CNT_W-1:0] db_cnt;
    logic             db_flip;
    logic             step;
    logic [2:0]       wait_cnt;

    // The FSM acts on the same edge the debounced level rises, so step is one cycle wide.
    assign db_flip = (sync_q[1] != db_level) && (db_cnt == CNT_LAST);
    assign step    = db_flip && !db_level;

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            sync_q   <= '0;
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            sync_q <= {sync_q[0], btn_step};
            if (sync_q[1] == db_level) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                db_level <= ~db_level;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) state_q <= S_A;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        state_d   = state_q;
        state_led = 3'b000;
        unique case (state_q)
            S_A: begin
                state_led = 3'b001;
                if (step) state_d = S_B;
            end
            S_B: begin
                state_led = 3'b010;
                if (step) state_d = S_OP;
            end
            S_OP: begin
                state_led = 3'b100;
                if (step) state_d = S_EXEC;
            end
            S_EXEC:  if (wait_cnt == LAT) state_d = S_CAP;
            S_CAP:   state_d = S_SHOW;
            S_SHOW:  if (step) state_d = S_A;
            default: state_d = S_A;
        endcase
    end

`ifdef ALSU_LIVE_RESULT_EN
    logic [6:0] live_tap;

    if (ALU_LATENCY == 1) begin : g_live_direct
        assign live_tap = {alu_invalid, alu_out};
    end else begin : g_live_pipe
        logic [6:0] live_q [ALU_LATENCY-1];

        // NOTE: the delay line is left unreset; it only feeds out_ALU in S_SHOW, by which time it has refilled.
        always_ff @(posedge clock_100Mhz) begin
            live_q[0] <= {alu_invalid, alu_out};
            for (int i = 1; i < ALU_LATENCY - 1; i++) begin
                live_q[i] <= live_q[i-1];
            end
        end

        assign live_tap = live_q[ALU_LATENCY-2];
    end
`endif

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            A        <= '0;
            B        <= '0;
            opcode   <= '0;
            out_ALU  <= '0;
            valid    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state_q)
                S_A: if (step) A <= sw_data;
                S_B: if (step) B <= sw_data;
                S_OP: begin
                    if (step) begin
                        opcode   <= sw_op;
                        wait_cnt <= '0;
                    end
                end
                S_EXEC: if (wait_cnt != LAT) wait_cnt <= wait_cnt + 3'd1;
                S_CAP: begin
                    out_ALU <= alu_out;
                    valid   <= ~alu_invalid;
                end
`ifdef ALSU_LIVE_RESULT_EN
                S_SHOW: begin
                    opcode  <= sw_op;
                    out_ALU <= live_tap[5:0];
                    valid   <= ~live_tap[6];
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
